// File: rtl/mm_pkg.sv
// Shared types and helpers for the memory-access (LSU) pipeline stage.
// Operation decode lives here so the stage and its lane aligner agree on sizes.
package mm_pkg;

    typedef enum logic [3:0] {
        MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
    } mem_op_t;

    typedef enum logic [1:0] {StIdle, StReq, StWait} lsu_state_t;

    function automatic logic op_is_load(mem_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    endfunction

    function automatic logic op_is_store(mem_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic op_is_signed(mem_op_t op);
        return op inside {LB, LH, LW};
    endfunction

    function automatic logic [3:0] op_size_bytes(mem_op_t op);
        case (op)
            LB, LBU, SB: return 4'd1;
            LH, LHU, SH: return 4'd2;
            LW, LWU, SW: return 4'd4;
            LD, SD:      return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/mm_lsu_if.sv
// Pipeline-in, pipeline-out and data-cache channels of the LSU stage.
// slave = the LSU itself; master = its environment (execute, writeback, cache).
interface mm_lsu_if #(
    parameter int unsigned ADDRESS_WIDTH    = 64,
    parameter int unsigned REGISTER_WIDTH   = 64,
    parameter int unsigned REGISTERNO_WIDTH = 5,
    parameter int unsigned BUS_WIDTH        = 64
) ();
    logic                          in_valid;
    logic                          in_ready;
    mm_pkg::mem_op_t               in_op;
    logic [ADDRESS_WIDTH-1:0]      in_alu_result;
    logic [REGISTER_WIDTH-1:0]     in_rs2_value;
    logic [REGISTERNO_WIDTH-1:0]   in_rd_regno;
    logic                          in_update_rd_bool;

    logic                          cache_req_valid;
    logic                          cache_req_ready;
    logic [ADDRESS_WIDTH-1:0]      cache_req_addr;
    logic                          cache_req_write;
    logic [BUS_WIDTH-1:0]          cache_req_wdata;
    logic [BUS_WIDTH/8-1:0]        cache_req_wstrb;
    logic                          cache_resp_valid;
    logic [BUS_WIDTH-1:0]          cache_resp_rdata;

    logic                          out_valid;
    logic                          wb_ready;
    logic [ADDRESS_WIDTH-1:0]      out_alu_result;
    logic [REGISTER_WIDTH-1:0]     out_mdata;
    logic [REGISTERNO_WIDTH-1:0]   out_rd_regno;
    logic                          out_update_rd_bool;
    logic                          out_mm_load_bool;
    logic                          out_misaligned;

    modport slave (
        input  in_valid, in_op, in_alu_result, in_rs2_value, in_rd_regno, in_update_rd_bool,
        input  cache_req_ready, cache_resp_valid, cache_resp_rdata, wb_ready,
        output in_ready, cache_req_valid, cache_req_addr, cache_req_write, cache_req_wdata,
        output cache_req_wstrb, out_valid, out_alu_result, out_mdata, out_rd_regno,
        output out_update_rd_bool, out_mm_load_bool, out_misaligned
    );

    modport master (
        output in_valid, in_op, in_alu_result, in_rs2_value, in_rd_regno, in_update_rd_bool,
        output cache_req_ready, cache_resp_valid, cache_resp_rdata, wb_ready,
        input  in_ready, cache_req_valid, cache_req_addr, cache_req_write, cache_req_wdata,
        input  cache_req_wstrb, out_valid, out_alu_result, out_mdata, out_rd_regno,
        input  out_update_rd_bool, out_mm_load_bool, out_misaligned
    );
endinterface

// File: rtl/mm_lane_align.sv
// Combinational byte-lane steering: load extraction/extension and store wdata/wstrb
// for an access at byte offset off_i within one cache bus word.
module mm_lane_align
    import mm_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH = 64,
    parameter int unsigned BUS_WIDTH      = 64,
    parameter int unsigned OFF_WIDTH      = $clog2(BUS_WIDTH / 8)
) (
    input  mem_op_t                 op_i,
    input  logic [OFF_WIDTH-1:0]    off_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_i,
    input  logic [BUS_WIDTH-1:0]    rdata_i,
    output logic [REGISTER_WIDTH-1:0] mdata_o,
    output logic [BUS_WIDTH-1:0]    wdata_o,
    output logic [BUS_WIDTH/8-1:0]  wstrb_o
);
    localparam int unsigned StrbW = BUS_WIDTH / 8;

    logic [BUS_WIDTH-1:0] field;
    logic [BUS_WIDTH-1:0] rep;
    logic [63:0]          st64;
    logic [3:0]           nbytes;
    logic                 sext;

    assign field  = rdata_i >> {off_i, 3'b000};
    assign st64   = 64'(rs2_i);
    assign nbytes = op_size_bytes(op_i);
    assign sext   = op_is_signed(op_i);

    always_comb begin
        mdata_o = '0;
        wdata_o = '0;
        wstrb_o = '0;
        rep     = '0;
        if (op_is_load(op_i)) begin
            case (nbytes)
                4'd1:    mdata_o = {{(REGISTER_WIDTH-8){sext & field[7]}}, field[7:0]};
                4'd2:    mdata_o = {{(REGISTER_WIDTH-16){sext & field[15]}}, field[15:0]};
                4'd4:    mdata_o = {{(REGISTER_WIDTH-32){sext & field[31]}}, field[31:0]};
                default: mdata_o = field[REGISTER_WIDTH-1:0];
            endcase
        end else if (op_is_store(op_i)) begin
            // Replicate first so every lane already carries the right byte before shifting.
            case (nbytes)
                4'd1:    rep = {StrbW{st64[7:0]}};
                4'd2:    rep = {(StrbW/2){st64[15:0]}};
                4'd4:    rep = {(StrbW/4){st64[31:0]}};
                default: rep = {(StrbW/8){st64}};
            endcase
            wdata_o = rep << {off_i, 3'b000};
            wstrb_o = StrbW'(((32'd1 << nbytes) - 32'd1) << off_i);
        end
    end

endmodule

// File: rtl/mm_lsu.sv
// Memory-access pipeline stage: issues data-cache requests for aligned loads/stores,
// faults misaligned ones, and passes non-memory results through a one-entry output register.
module mm_lsu
    import mm_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 64,
    parameter int unsigned REGISTER_WIDTH   = 64,
    parameter int unsigned REGISTERNO_WIDTH = 5,
    parameter int unsigned BUS_WIDTH        = 64
) (
    input logic      clk,
    input logic      reset,
    mm_lsu_if.slave  bus
);
    localparam int unsigned OffW = $clog2(BUS_WIDTH / 8);

    lsu_state_t                  state_q, state_d;
    mem_op_t                     op_q, op_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0]   rs2_q, rs2_d;
    logic [REGISTERNO_WIDTH-1:0] rd_q, rd_d;
    logic                        upd_q, upd_d;

    logic                        out_valid_q, out_valid_d;
    logic [ADDRESS_WIDTH-1:0]    out_alu_q, out_alu_d;
    logic [REGISTER_WIDTH-1:0]   out_mdata_q, out_mdata_d;
    logic [REGISTERNO_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                        out_upd_q, out_upd_d;
    logic                        out_load_q, out_load_d;
    logic                        out_mis_q, out_mis_d;

    logic [REGISTER_WIDTH-1:0]   ext_mdata;
    logic [BUS_WIDTH-1:0]        st_wdata;
    logic [BUS_WIDTH/8-1:0]      st_wstrb;
    logic                        in_ready, accept, in_is_mem, in_mis, req_active;
    logic [3:0]                  in_nbytes;

    mm_lane_align #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .BUS_WIDTH      (BUS_WIDTH)
    ) u_align (
        .op_i    (op_q),
        .off_i   (addr_q[OffW-1:0]),
        .rs2_i   (rs2_q),
        .rdata_i (bus.cache_resp_rdata),
        .mdata_o (ext_mdata),
        .wdata_o (st_wdata),
        .wstrb_o (st_wstrb)
    );

    assign in_nbytes = op_size_bytes(bus.in_op);
    assign in_is_mem = op_is_load(bus.in_op) || op_is_store(bus.in_op);
    assign in_mis    = in_is_mem && (|(bus.in_alu_result[3:0] & (in_nbytes - 4'd1)));
    // Held low while reset is asserted so nothing is taken during reset.
    assign in_ready  = reset && (state_q == StIdle) && (!out_valid_q || bus.wb_ready);
    assign accept    = bus.in_valid && in_ready;
    assign req_active = (state_q == StReq);

    assign bus.in_ready        = in_ready;
    assign bus.cache_req_valid = req_active;
    assign bus.cache_req_addr  = req_active ? {addr_q[ADDRESS_WIDTH-1:OffW], {OffW{1'b0}}} : '0;
    assign bus.cache_req_write = req_active && op_is_store(op_q);
    assign bus.cache_req_wdata = req_active ? st_wdata : '0;
    assign bus.cache_req_wstrb = req_active ? st_wstrb : '0;

    assign bus.out_valid          = out_valid_q;
    assign bus.out_alu_result     = out_alu_q;
    assign bus.out_mdata          = out_mdata_q;
    assign bus.out_rd_regno       = out_rd_q;
    assign bus.out_update_rd_bool = out_upd_q;
    assign bus.out_mm_load_bool   = out_load_q;
    assign bus.out_misaligned     = out_mis_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        upd_d       = upd_q;
        out_valid_d = out_valid_q && !bus.wb_ready;
        out_alu_d   = out_alu_q;
        out_mdata_d = out_mdata_q;
        out_rd_d    = out_rd_q;
        out_upd_d   = out_upd_q;
        out_load_d  = out_load_q;
        out_mis_d   = out_mis_q;
        case (state_q)
            StIdle: begin
                if (accept && in_is_mem && !in_mis) begin
                    op_d    = bus.in_op;
                    addr_d  = bus.in_alu_result;
                    rs2_d   = bus.in_rs2_value;
                    rd_d    = bus.in_rd_regno;
                    upd_d   = bus.in_update_rd_bool;
                    state_d = StReq;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_alu_d   = bus.in_alu_result;
                    out_mdata_d = '0;
                    out_rd_d    = bus.in_rd_regno;
                    out_upd_d   = bus.in_update_rd_bool && !in_mis;
                    out_load_d  = 1'b0;
                    out_mis_d   = in_mis;
                end
            end
            StReq: begin
                if (bus.cache_req_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.cache_resp_valid) begin
                    out_valid_d = 1'b1;
                    out_alu_d   = addr_q;
                    out_mdata_d = ext_mdata;
                    out_rd_d    = rd_q;
                    out_upd_d   = upd_q;
                    out_load_d  = op_is_load(op_q);
                    out_mis_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            op_q        <= MEM_NONE;
            addr_q      <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            upd_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            out_mdata_q <= '0;
            out_rd_q    <= '0;
            out_upd_q   <= 1'b0;
            out_load_q  <= 1'b0;
            out_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            upd_q       <= upd_d;
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            out_mdata_q <= out_mdata_d;
            out_rd_q    <= out_rd_d;
            out_upd_q   <= out_upd_d;
            out_load_q  <= out_load_d;
            out_mis_q   <= out_mis_d;
        end
    end

endmodule

// File: tb/tb_mm_lsu.sv
// Directed plus randomized bench for mm_lsu; the bench acts as execute, writeback and data cache.
module tb_mm_lsu;
    import mm_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mm_lsu_if bus ();

    mm_lsu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes_of(mem_op_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            LD, SD:      return 8;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_load(mem_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    endfunction

    function automatic bit is_store(mem_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic [63:0] exp_load(mem_op_t op, logic [63:0] addr, logic [63:0] rdata);
        int          off = int'(addr[2:0]);
        int          nb  = nbytes_of(op);
        logic [63:0] v, mask;
        v = rdata >> (8 * off);
        if (nb == 8) return v;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if ((op inside {LB, LH, LW}) && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] exp_wdata(mem_op_t op, logic [63:0] addr, logic [63:0] rs2);
        int          off = int'(addr[2:0]);
        int          nb  = nbytes_of(op);
        logic [63:0] w   = '0;
        if (!is_store(op)) return '0;
        for (int j = off; j < 8; j++) w[8*j +: 8] = rs2[8*((j - off) % nb) +: 8];
        return w;
    endfunction

    function automatic logic [7:0] exp_wstrb(mem_op_t op, logic [63:0] addr);
        int         off = int'(addr[2:0]);
        logic [7:0] s   = '0;
        if (!is_store(op)) return '0;
        for (int j = off; j < off + nbytes_of(op); j++) s[j] = 1'b1;
        return s;
    endfunction

    // One instruction end to end; called at a negedge with the stage idle.
    task automatic run_op(input mem_op_t op, input logic [63:0] addr, input logic [63:0] rs2,
                          input logic [63:0] rdata, input logic [4:0] rd, input logic upd,
                          input int stall, input int hold);
        bit mem = (op != MEM_NONE);
        bit mis = mem && ((addr % nbytes_of(op)) != 0);
        for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_alu_result = addr;
        bus.in_rs2_value = rs2;
        bus.in_rd_regno = rd;
        bus.in_update_rd_bool = upd;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op = MEM_NONE;
        if (!mem || mis) begin
            check("direct_valid", bus.out_valid, 1);
            check("direct_mis", bus.out_misaligned, mis);
            check("direct_upd", bus.out_update_rd_bool, upd && !mis);
            check("direct_load", bus.out_mm_load_bool, 0);
            check("direct_mdata", bus.out_mdata, 0);
            check("direct_alu", bus.out_alu_result, addr);
            check("direct_rd", bus.out_rd_regno, rd);
            check("direct_noreq", bus.cache_req_valid, 0);
        end else begin
            for (int s = 0; s <= stall; s++) begin
                check("req_valid", bus.cache_req_valid, 1);
                check("req_addr", bus.cache_req_addr, addr & ~64'd7);
                check("req_write", bus.cache_req_write, is_store(op));
                check("req_wdata", bus.cache_req_wdata, exp_wdata(op, addr, rs2));
                check("req_wstrb", bus.cache_req_wstrb, exp_wstrb(op, addr));
                if (s < stall) @(negedge clk);
            end
            check("req_outv", bus.out_valid, 0);
            bus.cache_req_ready = 1'b1;
            @(negedge clk);
            bus.cache_req_ready = 1'b0;
            check("wait_noreq", bus.cache_req_valid, 0);
            check("wait_inready", bus.in_ready, 0);
            if (hold > 0) bus.wb_ready = 1'b0;
            bus.cache_resp_valid = 1'b1;
            bus.cache_resp_rdata = rdata;
            @(negedge clk);
            bus.cache_resp_valid = 1'b0;
            check("resp_valid", bus.out_valid, 1);
            check("resp_load", bus.out_mm_load_bool, is_load(op));
            check("resp_mdata", bus.out_mdata, is_load(op) ? exp_load(op, addr, rdata) : 64'd0);
            check("resp_alu", bus.out_alu_result, addr);
            check("resp_rd", bus.out_rd_regno, rd);
            check("resp_upd", bus.out_update_rd_bool, upd);
            check("resp_mis", bus.out_misaligned, 0);
            if (hold > 0) begin
                bus.in_valid = 1'b1;
                bus.in_alu_result = 64'h5555;
                bus.in_rd_regno = 5'd7;
                bus.in_update_rd_bool = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_mdata", bus.out_mdata, exp_load(op, addr, rdata));
                    check("hold_inready", bus.in_ready, 0);
                end
                bus.wb_ready = 1'b1;
                #1;
                check("drain_inready", bus.in_ready, 1);
                @(negedge clk);
                bus.in_valid = 1'b0;
                check("replace_valid", bus.out_valid, 1);
                check("replace_alu", bus.out_alu_result, 64'h5555);
                check("replace_load", bus.out_mm_load_bool, 0);
                check("replace_rd", bus.out_rd_regno, 7);
            end
        end
        @(negedge clk);
        check("drained", bus.out_valid, 0);
    endtask

    initial begin
        mem_op_t     op;
        logic [63:0] a, r2, rd_data;
        int          nb;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = MEM_NONE;
        bus.in_alu_result = '0;
        bus.in_rs2_value = '0;
        bus.in_rd_regno = '0;
        bus.in_update_rd_bool = 1'b0;
        bus.cache_req_ready = 1'b0;
        bus.cache_resp_valid = 1'b0;
        bus.cache_resp_rdata = '0;
        bus.wb_ready = 1'b1;
        #12;
        check("rst_inready", bus.in_ready, 0);
        check("rst_outvalid", bus.out_valid, 0);
        check("rst_reqvalid", bus.cache_req_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(MEM_NONE, 64'h1234, 64'd0, 64'd0, 5'd3, 1'b1, 0, 0);
        run_op(LB,  64'h1003, 64'd0, 64'h00000000_80000000, 5'd4, 1'b1, 0, 0);
        run_op(LBU, 64'h1003, 64'd0, 64'h00000000_80000000, 5'd4, 1'b1, 0, 0);
        run_op(SH,  64'h2002, 64'hABCD, 64'd0, 5'd0, 1'b0, 3, 0);
        run_op(LW,  64'h3002, 64'd0, 64'd0, 5'd9, 1'b1, 0, 0);
        run_op(LD,  64'h4008, 64'd0, 64'hFEDC_BA98_7654_3210, 5'd10, 1'b1, 0, 4);

        for (int i = 0; i < 40; i++) begin
            op = mem_op_t'($urandom_range(0, 11));
            nb = nbytes_of(op);
            a  = {$urandom, $urandom};
            if (nb > 1 && $urandom_range(0, 4) != 0) a = a & ~(64'(nb) - 64'd1);
            r2 = {$urandom, $urandom};
            rd_data = {$urandom, $urandom};
            run_op(op, a, r2, rd_data, 5'($urandom), 1'($urandom), $urandom_range(0, 2), 0);
        end

        // Reset while waiting for a response; the late response must be dropped.
        run_op(MEM_NONE, 64'h1234, 64'd0, 64'd0, 5'd3, 1'b1, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_op = LW;
        bus.in_alu_result = 64'h40;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op = MEM_NONE;
        check("rw_req", bus.cache_req_valid, 1);
        bus.cache_req_ready = 1'b1;
        @(negedge clk);
        bus.cache_req_ready = 1'b0;
        check("rw_wait", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check("rw_rst_inready", bus.in_ready, 0);
        check("rw_rst_alu", bus.out_alu_result, 0);
        check("rw_rst_rd", bus.out_rd_regno, 0);
        check("rw_rst_upd", bus.out_update_rd_bool, 0);
        check("rw_rst_req", bus.cache_req_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rw_idle", bus.in_ready, 1);
        bus.cache_resp_valid = 1'b1;
        bus.cache_resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.cache_resp_valid = 1'b0;
        check("rw_ignored_valid", bus.out_valid, 0);
        check("rw_ignored_mdata", bus.out_mdata, 0);
        check("rw_ignored_req", bus.cache_req_valid, 0);
        run_op(LD, 64'h48, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd1, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_lsu.md
Name: mm_lsu

Overview:
- Parametrised successor to the current memory-access pipeline stage; sits between execute and writeback.
- Handles loads (byte, half, word, double; signed and unsigned) and stores (sb/sh/sw/sd).
- Talks to the data cache over a valid/ready request channel and a response channel, and detects misaligned accesses.
- Uses valid/ready handshakes on both pipeline sides, so upstream and downstream can stall independently.

Parameters:
- ADDRESS_WIDTH, 64, address width.
- REGISTER_WIDTH, 64, register/data width.
- REGISTERNO_WIDTH, 5, register index width.
- BUS_WIDTH, 64, cache data bus width. Must be a power of 2 and at least REGISTER_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  4  mem_op_t operation.
- in_alu_result  in  ADDRESS_WIDTH  effective address, or pass-through result for non-memory ops.
- in_rs2_value  in  REGISTER_WIDTH  store data.
- in_rd_regno  in  REGISTERNO_WIDTH  destination register.
- in_update_rd_bool  in  1  instruction writes rd.
- cache_req_valid  out  1  request present.
- cache_req_ready  in  1  cache takes the request.
- cache_req_addr  out  ADDRESS_WIDTH  address aligned down to BUS_WIDTH/8 bytes.
- cache_req_write  out  1  1 = store.
- cache_req_wdata  out  BUS_WIDTH  lane-shifted store data.
- cache_req_wstrb  out  BUS_WIDTH/8  byte enables.
- cache_resp_valid  in  1  read data or store ack.
- cache_resp_rdata  in  BUS_WIDTH  read bus word.
- out_valid  out  1  result register holds an instruction.
- wb_ready  in  1  downstream consumes.
- out_alu_result  out  ADDRESS_WIDTH  captured alu result.
- out_mdata  out  REGISTER_WIDTH  extended load data.
- out_rd_regno  out  REGISTERNO_WIDTH  destination.
- out_update_rd_bool  out  1  write rd.
- out_mm_load_bool  out  1  result comes from memory.
- out_misaligned  out  1  misaligned access fault.

Behaviour:
- Reset (asserted while reset=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, except in_ready, which is 0 during reset and follows the rule below after deassertion.
  - An in-flight cache transaction is abandoned; a later cache_resp_valid is ignored.
- FSM states: IDLE, REQ, WAIT.
- in_ready = (state==IDLE) && (!out_valid || wb_ready).
- Output register: cleared (out_valid<=0) when out_valid && wb_ready and nothing new is loaded. Contents stay stable while out_valid && !wb_ready.
- IDLE accept, non-memory op (MEM_NONE):
  - Next cycle, load the output register: out_valid=1, out_mm_load_bool=0, out_mdata=0.
  - Latency 1.
- IDLE accept, misaligned memory op (address not a multiple of the access size):
  - No cache request.
  - Next cycle out_valid=1, out_misaligned=1, out_update_rd_bool=0.
- IDLE accept, aligned memory op:
  - Capture op, address, data, rd and flags; go to REQ.
- REQ:
  - cache_req_valid=1; address, wdata and wstrb held constant.
  - When cache_req_ready=1, go to WAIT.
- WAIT:
  - On cache_resp_valid, load the output register and go to IDLE.
  - For loads: out_mm_load_bool=1 and out_mdata is the extracted value. For stores: out_mdata=0.
  - The output register is guaranteed empty at this point, because acceptance required it free or draining.
- cache_resp_valid while in IDLE or REQ is ignored.
- Minimum memory latency: accept at T, request at T+1 (ready the same cycle), response at T+2, out_valid at T+3.
- Load extraction:
  - off = addr[log2(BUS_WIDTH/8)-1:0]; field = rdata >> (8*off), truncated to size.
  - LB/LH/LW sign-extend to REGISTER_WIDTH; LBU/LHU/LWU zero-extend; LD is taken whole.
- Store encoding:
  - wdata = rs2 size-field replicated across the bus, then positioned at off.
  - wstrb = ((1<<bytes)-1) << off.
  - Loads drive wstrb=0 and wdata=0.
- Simultaneous drain and accept: when out_valid && wb_ready && in_valid with a non-memory op, the output is replaced the next cycle with no bubble.

Decomposition:
- Package mm_pkg holds:
  - mem_op_t enum: MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
  - Functions op_is_load, op_is_store, op_size_bytes, op_is_signed.
  - lsu_state_t enum.
- One sub-module, mm_lane_align (combinational), computes load extraction/extension and store wdata/wstrb from op, offset and data.

Test Plan:
- MEM_NONE, alu=0x1234, wb_ready=1 -> out_valid the next cycle, out_alu_result=0x1234, out_mm_load_bool=0, no cache_req_valid.
- LB at addr 0x1003, rdata=0x00000000_80000000 -> out_mdata=0xFFFFFFFF_FFFFFF80. The same with LBU -> 0x80.
- SH at 0x2002, rs2=0xABCD, cache_req_ready held 0 for 3 cycles -> request stable, wstrb=0x0C, wdata[31:16]=0xABCD, addr=0x2000. Completes on ack.
- LW at 0x3002 -> out_misaligned=1, out_update_rd_bool=0, no cache request, latency 1.
- LD with wb_ready=0 for 4 cycles after the result -> outputs held, in_ready=0, next instruction accepted the cycle wb_ready=1.
- reset=0 asserted in WAIT, then a response arrives after release -> all outputs 0, FSM IDLE, response ignored.
